// File: rtl/fdiv_pkg.sv
// rtl/fdiv_pkg.sv - shared divider-select types, encodings and controller state enum
//
// Contents:
//   SEL_W            width of the divider select (3)
//   sel_t            divider select type
//   SEL_DIV*         select encodings understood by the divider decoder
//   fsel_state_e     frequency-select controller FSM states
//   cnt_width()      counter width able to hold 0..n, never less than 1 bit

package fdiv_pkg;

  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_DIV1   = 3'd0;
  localparam sel_t SEL_DIV2   = 3'd1;
  localparam sel_t SEL_DIV4   = 3'd2;
  localparam sel_t SEL_DIV8   = 3'd3;
  localparam sel_t SEL_DIV16  = 3'd4;
  localparam sel_t SEL_DIV32  = 3'd5;
  localparam sel_t SEL_DIV64  = 3'd6;
  localparam sel_t SEL_DIV128 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WRAP = 2'd1,
    ST_SWITCH    = 2'd2,
    ST_SETTLE    = 2'd3
  } fsel_state_e;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fsel_tmo_cnt.sv
// rtl/fsel_tmo_cnt.sv - timeout counter with terminal flag for the select controller
//
// Counts Fin cycles while clr is low and saturates at TMO_CYC-1.
// Ports:
//   Fin      in   clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear; holds the count at zero
//   tc       out  terminal flag, high while the count equals TMO_CYC-1

module fsel_tmo_cnt
  import fdiv_pkg::*;
#(
  parameter int TMO_CYC = 1024
) (
  input  logic Fin,
  input  logic reset_n,
  input  logic clr,
  output logic tc
);

  localparam int CW = cnt_width(TMO_CYC);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge Fin or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fsel_ctrl.sv
// rtl/fsel_ctrl.sv - glitch-safe divider select controller with settle tracking
//
// Optional feature macro: FSEL_CTRL_TMO_EN (forced switch after TMO_CYC cycles
// without a divider wrap; without it the controller waits for wrap forever and
// tmo is tied low).
// Ports:
//   Fin      in   sole clock
//   reset_n  in   asynchronous active-low reset
//   req      in   frequency-change request, held until ack
//   req_sel  in   requested divider select, stable while req is high
//   wrap     in   divider terminal-count pulse, once per output period
//   ack      out  one-cycle acceptance pulse
//   busy     out  high while a switch is in progress
//   fsel     out  registered select driving the divider decoder
//   div_clr  out  one-cycle divider accumulator clear, coincident with fsel update
//   locked   out  high when fsel is stable and settled
//   tmo      out  sticky forced-switch flag, cleared only by reset

module fsel_ctrl
  import fdiv_pkg::*;
#(
  parameter sel_t SEL_RST    = SEL_DIV1,
  parameter int   SETTLE_PER = 2,
  parameter int   TMO_CYC    = 1024
) (
  input  logic       Fin,
  input  logic       reset_n,
  input  logic       req,
  input  logic [2:0] req_sel,
  input  logic       wrap,
  output logic       ack,
  output logic       busy,
  output logic [2:0] fsel,
  output logic       div_clr,
  output logic       locked,
  output logic       tmo
);

  localparam int PW = cnt_width(SETTLE_PER);
  localparam logic [PW-1:0] PER_LAST = PW'((SETTLE_PER > 0) ? SETTLE_PER - 1 : 0);

  fsel_state_e   state;
  sel_t          pend;
  logic [PW-1:0] per_cnt;
  logic          tmo_hit;

`ifdef FSEL_CTRL_TMO_EN
  logic tmo_tc;
  logic tmo_r;

  // Counter runs only in WAIT_WRAP, so it is zero on the first WAIT_WRAP cycle.
  fsel_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo_cnt (
    .Fin     (Fin),
    .reset_n (reset_n),
    .clr     (state != ST_WAIT_WRAP),
    .tc      (tmo_tc)
  );

  assign tmo_hit = tmo_tc;

  // A wrap in the timeout cycle wins: the exit is a normal one and tmo stays put.
  always_ff @(posedge Fin or negedge reset_n) begin
    if (!reset_n) begin
      tmo_r <= 1'b0;
    end else if (state == ST_WAIT_WRAP && !wrap && tmo_tc) begin
      tmo_r <= 1'b1;
    end
  end

  assign tmo = tmo_r;
`else
  assign tmo_hit = 1'b0;
  assign tmo     = 1'b0;
`endif

  always_ff @(posedge Fin or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      fsel    <= SEL_RST;
      pend    <= SEL_RST;
      ack     <= 1'b0;
      div_clr <= 1'b0;
      locked  <= 1'b1;
      busy    <= 1'b0;
      per_cnt <= '0;
    end else begin
      ack     <= 1'b0;
      div_clr <= 1'b0;
      case (state)
        ST_IDLE: begin
          // req is still high in the cycle ack is shown; ignoring it there
          // keeps one held request from being acknowledged twice.
          if (req && !ack) begin
            ack <= 1'b1;
            if (req_sel != fsel) begin
              pend  <= req_sel;
              busy  <= 1'b1;
              state <= ST_WAIT_WRAP;
            end
          end
        end
        ST_WAIT_WRAP: begin
          if (wrap || tmo_hit) begin
            state <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          // Switching right after a wrap keeps the divider from emitting a runt period.
          fsel    <= pend;
          div_clr <= 1'b1;
          per_cnt <= '0;
          if (SETTLE_PER == 0) begin
            locked <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            locked <= 1'b0;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (wrap) begin
            if (per_cnt == PER_LAST) begin
              per_cnt <= '0;
              locked  <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsel_ctrl.sv
// tb/tb_fsel_ctrl.sv - scoreboard bench for fsel_ctrl with a timeline reference model

module tb_fsel_ctrl;

  localparam int         SP   = 2;
  localparam int         TMO  = 16;
  localparam int         MAXC = 1200;
  localparam logic [2:0] SRST = 3'd2;
`ifdef FSEL_CTRL_TMO_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       Fin = 1'b0;
  logic       reset_n;
  logic       req;
  logic [2:0] req_sel;
  logic       wrap;
  logic       ack;
  logic       busy;
  logic [2:0] fsel;
  logic       div_clr;
  logic       locked;
  logic       tmo;

  always #5 Fin = ~Fin;

  fsel_ctrl #(
    .SEL_RST    (SRST),
    .SETTLE_PER (SP),
    .TMO_CYC    (TMO)
  ) dut (
    .Fin     (Fin),
    .reset_n (reset_n),
    .req     (req),
    .req_sel (req_sel),
    .wrap    (wrap),
    .ack     (ack),
    .busy    (busy),
    .fsel    (fsel),
    .div_clr (div_clr),
    .locked  (locked),
    .tmo     (tmo)
  );

  typedef enum int {EV_ACK, EV_DCLR, EV_LOCK} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    int         cyc;
    logic [2:0] sel;
    logic       tmo;
  } ev_t;
  typedef struct {
    int         r;
    int         a;
    int         d;
    int         l;
    logic [2:0] sel;
    bit         sw;
    bit         abort;
  } plan_t;

  ev_t   sbq[$];
  plan_t plans[$];

  // Timeline indexed by posedge number n: inputs sampled at posedge n,
  // expected outputs as seen between posedge n and posedge n+1.
  bit         wsch[0:MAXC+1];
  bit         reqv[0:MAXC+1];
  logic [2:0] selv[0:MAXC+1];
  bit         rstv[0:MAXC+1];
  bit         e_busy[0:MAXC+1];
  logic [2:0] e_fsel[0:MAXC+1];
  bit         e_lock[0:MAXC+1];
  bit         e_tmo[0:MAXC+1];

  int         idle_ok;
  int         last_a;
  logic [2:0] cur_fsel;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         running = 1'b0;
  bit         prev_lock = 1'b1;

  always @(posedge Fin) cyc <= cyc + 1;

  task automatic plan_req(input int r, input logic [2:0] sel, input int woff);
    plan_t p;
    int x, cnt;
    bit to;
    p.r = r; p.sel = sel; p.abort = 1'b0; to = 1'b0;
    p.a = (r > idle_ok) ? r : idle_ok;
    for (int n = r; n <= p.a; n++) begin reqv[n] = 1'b1; selv[n] = sel; end
    last_a = p.a;
    p.sw = (sel != cur_fsel);
    p.d = -1; p.l = -1;
    if (!p.sw) begin
      idle_ok = p.a + 2;
    end else begin
      if (woff > 0) wsch[p.a + woff] = 1'b1;
      x = MAXC;
      for (int n = p.a + 1; n < MAXC; n++) begin
        if (wsch[n]) begin x = n; break; end
        if (TMO_ON && n == p.a + TMO) begin x = n; to = 1'b1; break; end
      end
      p.d = x + 1;
      p.l = MAXC;
      cnt = 0;
      if (SP == 0) p.l = p.d;
      else begin
        for (int n = p.d + 1; n < MAXC; n++) begin
          if (wsch[n]) begin
            cnt++;
            if (cnt == SP) begin p.l = n; break; end
          end
        end
      end
      for (int n = p.a; n < MAXC; n++) begin
        e_busy[n] = (n < p.l);
        if (n >= p.d) e_fsel[n] = sel;
        e_lock[n] = !(n >= p.d && n < p.l);
        if (to && n >= x) e_tmo[n] = 1'b1;
      end
      cur_fsel = sel;
      idle_ok  = p.l + 1;
    end
    plans.push_back(p);
  endtask

  task automatic apply_reset(input int z, input int len);
    for (int n = z; n < z + len; n++) rstv[n] = 1'b0;
    for (int n = z; n < MAXC; n++) begin
      e_busy[n] = 1'b0; e_fsel[n] = SRST; e_lock[n] = 1'b1; e_tmo[n] = 1'b0;
    end
    cur_fsel = SRST;
    idle_ok  = z + len + 1;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v, input int n);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, n, act, exp_v);
    end
  endtask

  task automatic ev_chk(input ev_kind_e k, input int n);
    total++;
    if (sbq.size() == 0 || sbq[0].kind != k) begin
      bad++;
      $display("FAIL unexpected_%s cycle=%0d actual=1 expected=0", k.name(), n);
    end else begin
      if (sbq[0].cyc != n) begin
        bad++;
        $display("FAIL %s_cycle actual=%0d expected=%0d", k.name(), n, sbq[0].cyc);
      end else if (k == EV_DCLR) begin
        chk("dclr_fsel", int'(fsel), int'(sbq[0].sel), n);
        chk("dclr_tmo", int'(tmo), int'(sbq[0].tmo), n);
      end
      void'(sbq.pop_front());
    end
  endtask

  // Monitor: per-cycle state checks plus scoreboard pops on output events.
  always @(negedge Fin) begin
    if (running) begin
      chk("busy", int'(busy), int'(e_busy[cyc]), cyc);
      chk("fsel", int'(fsel), int'(e_fsel[cyc]), cyc);
      chk("locked", int'(locked), int'(e_lock[cyc]), cyc);
      chk("tmo", int'(tmo), int'(e_tmo[cyc]), cyc);
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_%s cycle=%0d actual=0 expected=1", sbq[0].kind.name(), sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (ack) ev_chk(EV_ACK, cyc);
      if (div_clr) ev_chk(EV_DCLR, cyc);
      if (locked && !prev_lock) ev_chk(EV_LOCK, cyc);
      prev_lock = locked;
    end
  end

  initial begin
    int pi;
    int r;
    logic [2:0] sel;

    for (int n = 0; n <= MAXC + 1; n++) begin
      wsch[n] = 1'b0; reqv[n] = 1'b0; selv[n] = 3'd0; rstv[n] = 1'b1;
      e_busy[n] = 1'b0; e_fsel[n] = SRST; e_lock[n] = 1'b1; e_tmo[n] = 1'b0;
    end
    cur_fsel = SRST; idle_ok = 0; last_a = 0;
    apply_reset(0, 4);

    // Directed: wrap every 8, switch to 5, second request during SETTLE, same-select request.
    for (int n = 32; n < 150; n++) wsch[n] = (n % 8 == 0);
    plan_req(33, 3'd5, 0);
    plan_req(plans[0].d + 2, 3'd3, 0);
    plan_req(idle_ok + 2, cur_fsel, 0);

    // Random wraps and requests, some issued while still busy.
    for (int n = 150; n < 700; n++) wsch[n] = ($urandom_range(0, 4) == 0);
    while (idle_ok < 560) begin
      if ($urandom_range(0, 2) == 0) r = idle_ok - int'($urandom_range(1, 8));
      else r = idle_ok + int'($urandom_range(0, 5));
      if (r < last_a + 2) r = last_a + 2;
      if (r < 152) r = 152;
      sel = ($urandom_range(0, 3) == 0) ? cur_fsel : 3'($urandom_range(0, 7));
      plan_req(r, sel, 0);
    end

    // Wrap landing exactly on the timeout cycle.
    for (int n = 760; n < 830; n++) wsch[n] = (n % 8 == 0);
    plan_req((idle_ok > 702) ? idle_ok : 702, cur_fsel + 3'd1, TMO);

    // Long wrap gap: forced switch with timeout enabled, otherwise keeps waiting.
    for (int n = 890; n < 950; n++) wsch[n] = (n % 8 == 0);
    plan_req((idle_ok > 832) ? idle_ok : 832, cur_fsel + 3'd1, 0);

    // Reset in WAIT_WRAP abandons the request, then a fresh switch.
    plan_req((idle_ok > 952) ? idle_ok : 952, cur_fsel + 3'd1, 0);
    plans[plans.size() - 1].abort = 1'b1;
    apply_reset(plans[plans.size() - 1].a + 3, 2);
    for (int n = 1011; n < MAXC; n++) wsch[n] = (n % 8 == 0);
    plan_req(1000, 3'd7, 0);

    pi = 0;
    reset_n = rstv[0]; wrap = wsch[1]; req = reqv[1]; req_sel = selv[1];
    running = 1'b1;
    for (int n = 1; n < MAXC; n++) begin
      @(posedge Fin);
      #1;
      reset_n = rstv[n];
      wrap    = wsch[n + 1];
      req     = reqv[n + 1];
      req_sel = selv[n + 1];
      if (pi < plans.size() && plans[pi].r == n + 1) begin
        sbq.push_back('{EV_ACK, plans[pi].a, plans[pi].sel, 1'b0});
        if (plans[pi].sw && !plans[pi].abort) begin
          sbq.push_back('{EV_DCLR, plans[pi].d, plans[pi].sel, e_tmo[plans[pi].d]});
          sbq.push_back('{EV_LOCK, plans[pi].l, plans[pi].sel, 1'b0});
        end
        pi++;
      end
    end
    @(negedge Fin);
    #2;
    running = 1'b0;
    chk("leftover_events", sbq.size(), 0, cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
